// File: rtl/ped_xing_scheduler.sv
// Pedestrian crossing phase scheduler: two debounced kerb buttons merged
// into one walk service, timed vehicle/pedestrian phases and night flash.
module ped_xing_scheduler #(
  parameter int TICK_DIV  = 12000000,
  parameter int DEBOUNCE  = 240000,
  parameter int MIN_GREEN = 4,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6,
  parameter int FLASH_T   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       night_mode,
  output logic       car_r,
  output logic       car_y,
  output logic       car_g,
  output logic       ped_r,
  output logic       ped_g,
  output logic       wait_a,
  output logic       wait_b,
  output logic [2:0] state_o
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int CW = 8;

  typedef enum logic [2:0] {
    GREEN  = 3'd0,
    YELLOW = 3'd1,
    ALLRED = 3'd2,
    WALK   = 3'd3,
    FLASH  = 3'd4,
    NIGHT  = 3'd5
  } phase_e;

  phase_e          state, nxt;
  logic [1:0]      rst_sr;
  logic            rst_i_n;
  logic [2:0]      s1, s2;
  logic [1:0]      db;
  logic [DW-1:0]   dcnt [2];
  logic [1:0]      press;
  logic [PW-1:0]   pre;
  logic [CW-1:0]   tcnt;
  logic            tick, enter, blink;
  logic            green_ok, clr, acc;

  // Reset asserts at once, releases on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sr <= '0;
    else        rst_sr <= {rst_sr[0], 1'b1};
  end
  assign rst_i_n = rst_sr[1];

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {night_mode, btn_b, btn_a};
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      db <= '0;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEBOUNCE - 1)) begin
          db[i]   <= s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  // Press fires on the clock the debounced level rises
  always_comb begin
    press = '0;
    for (int i = 0; i < 2; i++)
      press[i] = s2[i] & ~db[i] & (dcnt[i] == DW'(DEBOUNCE - 1));
  end

  assign tick = (pre == PW'(TICK_DIV - 1));
  assign green_ok = (tcnt >= CW'(MIN_GREEN)) ||
                    (tick && tcnt == CW'(MIN_GREEN - 1));

  always_comb begin
    nxt = state;
    unique case (state)
      GREEN: begin
        if (s2[2])
          nxt = NIGHT;
        else if ((wait_a | wait_b) && green_ok)
          nxt = YELLOW;
      end
      YELLOW: if (tick && tcnt == CW'(YELLOW_T - 1)) nxt = ALLRED;
      ALLRED: if (tick && tcnt == CW'(ALLRED_T - 1)) nxt = WALK;
      WALK:   if (tick && tcnt == CW'(WALK_T - 1))   nxt = FLASH;
      FLASH:  if (tick && tcnt == CW'(FLASH_T - 1))  nxt = GREEN;
      NIGHT:  if (!s2[2]) nxt = GREEN;
      default: nxt = GREEN;
    endcase
  end

  assign enter = (nxt != state);
  assign clr   = enter && (nxt == WALK || nxt == NIGHT);
  assign acc   = (state == GREEN) || (state == YELLOW) || (state == ALLRED);

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state  <= GREEN;
      pre    <= '0;
      tcnt   <= '0;
      blink  <= 1'b0;
      wait_a <= 1'b0;
      wait_b <= 1'b0;
    end else begin
      state <= nxt;
      if (enter) begin
        pre  <= '0;
        tcnt <= '0;
      end else begin
        pre <= tick ? '0 : pre + PW'(1);
        if (tick && tcnt != '1) tcnt <= tcnt + CW'(1);
      end
      if (enter && (nxt == FLASH || nxt == NIGHT)) blink <= 1'b1;
      else if (tick)                               blink <= ~blink;
      wait_a <= clr ? 1'b0 : (wait_a | (acc & press[0]));
      wait_b <= clr ? 1'b0 : (wait_b | (acc & press[1]));
    end
  end

  always_comb begin
    car_r = 1'b0;
    car_y = 1'b0;
    car_g = 1'b0;
    ped_r = 1'b0;
    ped_g = 1'b0;
    unique case (state)
      GREEN:  begin car_g = 1'b1; ped_r = 1'b1; end
      YELLOW: begin car_y = 1'b1; ped_r = 1'b1; end
      ALLRED: begin car_r = 1'b1; ped_r = 1'b1; end
      WALK:   begin car_r = 1'b1; ped_g = 1'b1; end
      FLASH:  begin car_r = 1'b1; ped_g = blink; end
      NIGHT:  car_y = blink;
      default: begin car_r = 1'b1; ped_r = 1'b1; end
    endcase
  end

  assign state_o = state;

endmodule

// File: doc/ped_xing_scheduler.md
Name: ped_xing_scheduler

Overview:
- Phase scheduler for a single-road pedestrian crossing with two crossing buttons, one per kerb side.
- Debounces and latches both requests and merges them into one walk service.
- Enforces minimum vehicle green, yellow, all-red clearance, walk and flashing-walk phases, plus a night flash mode.
- Drives the car and pedestrian lamp signals for the board LED stage; LED polarity inversion is handled outside this block.

Parameters:
TICK_DIV, 12000000, clk cycles per phase tick (1 s at 12 MHz)
DEBOUNCE, 240000, consecutive stable synchronised cycles needed to accept a button level (20 ms)
MIN_GREEN, 4, ticks of vehicle green before a request may be honoured
YELLOW_T, 3, ticks of vehicle yellow
ALLRED_T, 1, ticks of all-red clearance
WALK_T, 6, ticks of steady pedestrian green
FLASH_T, 4, ticks of flashing pedestrian green (vehicle red)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
btn_a  in  1  raw pedestrian button, side A (asynchronous)
btn_b  in  1  raw pedestrian button, side B (asynchronous)
night_mode  in  1  raw night-flash request (asynchronous)
car_r/car_y/car_g  out  1 each  vehicle lamps, active-high
ped_r/ped_g  out  1 each  pedestrian lamps, active-high
wait_a/wait_b  out  1 each  "request registered" indicators
state_o  out  3  current phase code

Behaviour:
- Input conditioning:
  - btn_a, btn_b and night_mode each pass through a 2-FF synchroniser.
  - The buttons then pass through a debouncer. The debounced level changes only after DEBOUNCE consecutive equal synchronised samples.
  - A debounced rising edge is a press. A held button produces one press only.
- Phase codes: GREEN=0, YELLOW=1, ALLRED=2, WALK=3, FLASH=4, NIGHT=5. Codes 6 and 7 recover to GREEN on the next clock.
- Timing:
  - The prescaler counts 0..TICK_DIV-1 and pulses tick at terminal count.
  - The prescaler and phase tick counter both clear on every phase entry, so a phase of D ticks lasts exactly D*TICK_DIV cycles.
  - GREEN has no maximum duration.
- Transitions (evaluated each clk):
  - GREEN: night_sync=1 -> NIGHT (takes priority). Otherwise, if (wait_a|wait_b) and MIN_GREEN ticks have elapsed -> YELLOW on that clock.
  - YELLOW: after YELLOW_T ticks -> ALLRED.
  - ALLRED: after ALLRED_T ticks -> WALK.
  - WALK: after WALK_T ticks -> FLASH.
  - FLASH: after FLASH_T ticks -> GREEN, with the min-green window restarting.
  - NIGHT: when night_sync=0 -> GREEN, with the min-green window restarting. night_mode is ignored outside GREEN and NIGHT.
- Requests:
  - A press on side x sets wait_x in GREEN, YELLOW or ALLRED.
  - Presses in WALK, FLASH or NIGHT are discarded.
  - Both wait flags clear on the clock that enters WALK, so one walk serves both sides.
  - Entering NIGHT clears both flags.
  - A simultaneous press on A and B sets both flags and produces a single service.
- Lamp decode (combinational from the registered phase and a blink flop):
  - GREEN: car_g, ped_r.
  - YELLOW: car_y, ped_r.
  - ALLRED: car_r, ped_r.
  - WALK: car_r, ped_g.
  - FLASH: car_r, ped_g=blink.
  - NIGHT: car_y=blink, all pedestrian lamps off.
- Blink flop: set to 1 on FLASH/NIGHT entry, toggles on every tick.
- Reset (async assert, sync deassert via clk):
  - Phase GREEN, prescaler/counters/debouncers/synchronisers 0, wait_a=wait_b=0, blink=0.
  - Outputs: car_g=1, ped_r=1, all others 0, state_o=0.
  - Reset mid-phase forces these values immediately, and the min-green window restarts.

Test Plan:
Parameter set for all scenarios: TICK_DIV=4, DEBOUNCE=3, MIN_GREEN=2, YELLOW_T=2, ALLRED_T=1, WALK_T=3, FLASH_T=2.
1. Reset released, no stimulus for 100 cycles -> state_o=0, car_g=1, ped_r=1, wait_a=wait_b=0 throughout.
2. Full sequence with btn_a held 10 cycles starting at cycle 20 after reset:
   - wait_a rises 5 cycles after btn_a's rising edge; YELLOW begins the following clock.
   - YELLOW lasts 8 cycles, ALLRED lasts 4.
   - WALK lasts 12 cycles, and wait_a drops on WALK entry.
   - FLASH lasts 8 cycles, with ped_g=1,0 per 4-cycle tick.
   - The sequence then returns to GREEN.
3. Press btn_b 1 cycle after re-entering GREEN:
   - wait_b is set, but YELLOW is entered only once 8 cycles have elapsed since GREEN entry.
   - No early transition occurs.
4. Button timing cases:
   - btn_a and btn_b rise on the same cycle -> both waits set, a single WALK, both waits cleared at WALK entry.
   - A 2-cycle glitch on btn_a -> no wait_a.
5. Press during WALK, then idle 200 cycles -> no wait flag set, and GREEN holds indefinitely after FLASH.
6. Night mode:
   - night_mode=1 in GREEN with wait_a set -> NIGHT within 3 cycles, wait_a cleared, car_y toggling every 4 cycles, ped lamps off.
   - night_mode=0 -> GREEN.
   - rst_n pulsed low mid-YELLOW -> GREEN outputs asynchronously.
